// File: rtl/lsu_bus_master_pkg.sv
// Shared encodings for the LSU bus master: ctr_m field positions, access sizes,
// FSM states and the byte-lane rotation helpers used for big-endian lane placement.
package lsu_bus_master_pkg;

    localparam int CTR_WR_BIT   = 0;
    localparam int CTR_RD_BIT   = 1;
    localparam int CTR_SIZE_LSB = 2;
    localparam int CTR_UNS_BIT  = 4;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BEAT1 = 2'b01,
        BEAT2 = 2'b10,
        DONE  = 2'b11
    } state_e;

    function automatic logic [2:0] size_len(input size_e size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic is_misaligned(input size_e size, input logic [1:0] off);
        case (size)
            SZ_HALF: return off[0];
            SZ_WORD: return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    // Byte offset 0 lives in bits [31:24], so moving toward higher offsets is a right rotate.
    function automatic logic [31:0] rotr_bytes(input logic [31:0] x, input logic [1:0] n);
        case (n)
            2'd0:    return x;
            2'd1:    return {x[7:0],  x[31:8]};
            2'd2:    return {x[15:0], x[31:16]};
            default: return {x[23:0], x[31:24]};
        endcase
    endfunction

    function automatic logic [31:0] rotl_bytes(input logic [31:0] x, input logic [1:0] n);
        case (n)
            2'd0:    return x;
            2'd1:    return {x[23:0], x[31:24]};
            2'd2:    return {x[15:0], x[31:16]};
            default: return {x[7:0],  x[31:8]};
        endcase
    endfunction

endpackage

// File: rtl/lsu_bus_master_lane_align.sv
// Combinational lane steering for the LSU: store data placement and per-beat byte
// enables, plus gathering of assembled load bytes with sign/zero extension.
module lsu_lane_align
    import lsu_bus_master_pkg::*;
(
    input  size_e       size_i,
    input  logic [1:0]  offset_i,
    input  logic        unsigned_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] assembled_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  be_first_o,
    output logic [3:0]  be_second_o,
    output logic [31:0] load_data_o
);

    logic [4:0]  span_end;
    logic [31:0] store_left;
    logic [31:0] load_rot;

    // The access covers byte offsets [offset, span_end) of an 8-byte window; lane i is offset 3-i.
    always_comb begin
        span_end = {3'b000, offset_i} + {2'b00, size_len(size_i)};
        for (int i = 0; i < 4; i++) begin
            be_first_o[i]  = (5'(3 - i) >= {3'b000, offset_i}) && (5'(3 - i) < span_end);
            be_second_o[i] = 5'(7 - i) < span_end;
        end

        case (size_i)
            SZ_BYTE: store_left = {store_data_i[7:0], 24'h000000};
            SZ_HALF: store_left = {store_data_i[15:0], 16'h0000};
            default: store_left = store_data_i;
        endcase
        wdata_o = rotr_bytes(store_left, offset_i);

        load_rot = rotl_bytes(assembled_i, offset_i);
        case (size_i)
            SZ_BYTE: load_data_o = unsigned_i ? {24'h000000, load_rot[31:24]}
                                              : {{24{load_rot[31]}}, load_rot[31:24]};
            SZ_HALF: load_data_o = unsigned_i ? {16'h0000, load_rot[31:16]}
                                              : {{16{load_rot[31]}}, load_rot[31:16]};
            default: load_data_o = load_rot;
        endcase
    end

endmodule

// File: rtl/lsu_bus_master.sv
// Load/store bus initiator: turns one EX/MEM access into one or two req/ack word beats,
// stalls the pipeline meanwhile and returns extended load data with a one-cycle pulse.
module lsu_bus_master
    import lsu_bus_master_pkg::*;
#(
    parameter int ADDR_W   = 9,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        ctr_m,
    input  logic [31:0]       ALU_out,
    input  logic [31:0]       reg2_data,
    output logic              stall,
    output logic [31:0]       load_data,
    output logic              load_valid,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

    state_e            state_q;
    size_e             size_q;
    logic              write_q;
    logic              unsigned_q;
    logic              split_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       store_q;
    logic [3:0]        wait_q;
    logic [31:0]       asm_q;
    logic [31:0]       asm_d;
    logic [31:0]       load_data_q;
    logic              load_valid_q;
    logic              err_q;

    logic              req_rd;
    logic              req_wr;
    size_e             req_size;
    logic              access;
    logic              illegal;
    logic              in_beat;
    logic [ADDR_W-1:0] word_addr;
    logic [3:0]        be_first;
    logic [3:0]        be_second;
    logic [3:0]        beat_be;
    logic [31:0]       lane_wdata;
    logic [31:0]       load_ext;
    logic              unused_inputs;

    assign req_wr   = ctr_m[CTR_WR_BIT];
    assign req_rd   = ctr_m[CTR_RD_BIT];
    assign req_size = size_e'(ctr_m[CTR_SIZE_LSB +: 2]);
    assign access   = (req_rd ^ req_wr) && (req_size != SZ_RSVD);
    assign illegal  = (req_rd && req_wr) || ((req_rd || req_wr) && (req_size == SZ_RSVD));

    assign unused_inputs = ^{ctr_m[5], ALU_out[31:ADDR_W]};

    assign in_beat   = (state_q == BEAT1) || (state_q == BEAT2);
    assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};
    assign beat_be   = (state_q == BEAT2) ? be_second : be_first;

    // Bus signals decode straight from state so a reset drops mem_req without waiting for a clock.
    assign stall     = in_beat || ((state_q == IDLE) && access);
    assign mem_req   = in_beat;
    assign mem_we    = in_beat && write_q;
    assign mem_addr  = !in_beat           ? '0
                     : (state_q == BEAT2) ? word_addr + ADDR_W'(4)
                     :                      word_addr;
    assign mem_be    = in_beat ? beat_be : 4'b0000;
    assign mem_wdata = mem_we ? lane_wdata : 32'h0000_0000;

    assign load_data  = load_data_q;
    assign load_valid = load_valid_q;
    assign err        = err_q;

    always_comb begin
        asm_d = asm_q;
        for (int i = 0; i < 4; i++) begin
            if (beat_be[i]) begin
                asm_d[8*i +: 8] = mem_rdata[8*i +: 8];
            end
        end
    end

    lsu_lane_align u_lane_align (
        .size_i       (size_q),
        .offset_i     (addr_q[1:0]),
        .unsigned_i   (unsigned_q),
        .store_data_i (store_q),
        .assembled_i  (asm_d),
        .wdata_o      (lane_wdata),
        .be_first_o   (be_first),
        .be_second_o  (be_second),
        .load_data_o  (load_ext)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            size_q       <= SZ_BYTE;
            write_q      <= 1'b0;
            unsigned_q   <= 1'b0;
            split_q      <= 1'b0;
            addr_q       <= '0;
            store_q      <= 32'h0000_0000;
            wait_q       <= 4'd0;
            asm_q        <= 32'h0000_0000;
            load_data_q  <= 32'h0000_0000;
            load_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            load_valid_q <= 1'b0;
            err_q        <= 1'b0;
            case (state_q)
                IDLE: begin
                    wait_q <= 4'd0;
                    if (access) begin
                        size_q     <= req_size;
                        write_q    <= req_wr;
                        unsigned_q <= ctr_m[CTR_UNS_BIT];
                        split_q    <= is_misaligned(req_size, ALU_out[1:0]);
                        addr_q     <= ALU_out[ADDR_W-1:0];
                        store_q    <= reg2_data;
                        asm_q      <= 32'h0000_0000;
                        state_q    <= BEAT1;
                    end else if (illegal) begin
                        err_q <= 1'b1;
                    end
                end
                BEAT1, BEAT2: begin
                    if (mem_ack) begin
                        asm_q  <= asm_d;
                        wait_q <= 4'd0;
                        if ((state_q == BEAT1) && split_q) begin
                            state_q <= BEAT2;
                        end else begin
                            state_q      <= DONE;
                            load_valid_q <= !write_q;
                            if (!write_q) begin
                                load_data_q <= load_ext;
                            end
                        end
                    end else if (wait_q == WAIT_LAST) begin
                        // Abandon the access: a read still reports completion, with zero data.
                        state_q      <= DONE;
                        err_q        <= 1'b1;
                        load_valid_q <= !write_q;
                        load_data_q  <= 32'h0000_0000;
                    end else begin
                        wait_q <= wait_q + 4'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
